instruction_decode_pipe: RTL
============================

Name: instruction_decode_pipe

Overview:
- Parametrised, registered successor of the decode stage.
- Decodes one instruction per cycle and reads an internal 2^W-entry register file with write-through bypass from WB.
- Detects load-use hazards and inserts bubbles; honours a flush from MEM (taken branch).
- Drives a registered ID/EX bundle to the execute stage; the IF-stage redirect for j/jal/jr/jalr is combinational.

Parameters:
- B, 32, data/instruction word width (≥32).
- W, 5, register address bits; register file depth is 2^W.
- BYPASS_EN, 1, 1 = same-cycle WB write is forwarded to the ID read ports.
- HAZARD_EN, 1, 1 = load-use stall logic enabled; 0 = stall_out tied 0.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears pipeline register and register file.
- valid_in  in  1  IF/ID holds a valid instruction.
- instruction  in  B  IF/ID instruction.
- pc_incrementado  in  B  PC+4 of that instruction.
- flush  in  1  squash the instruction currently in ID (taken branch).
- RegWrite  in  1  WB write enable.
- address_write  in  W  WB destination register.
- data_write  in  B  WB data.
- stall_out  out  1  hold PC and IF/ID this cycle (combinational).
- jump_taken  out  1  redirect IF this cycle (combinational).
- pc_jump  out  B  jump target (combinational).
- valid_out  out  1  ID/EX holds a valid instruction.
- reg_data1, reg_data2  out  B  operands (registered).
- sgn_extend_data_imm  out  B  sign-extended imm[15:0] (registered).
- rt, rd  out  W  source rt; resolved destination (registered).
- wb_RegWrite_out, wb_MemtoReg_out, m_MemRead_out, m_MemWrite_out, m_Branch_out, m_BranchNot_out, ex_ALUSrc_out  out  1 each  control (registered).
- ex_ALUOp_out  out  6  opcode, or func when R-type (registered).

Behaviour:
- Reset (async):
  - All registered outputs = 0, valid_out = 0.
  - All registers = 0.
  - Release is synchronous to clk.
- Register file:
  - Write on posedge when RegWrite && address_write != 0.
  - Register 0 always reads 0.
  - BYPASS_EN=1: a read whose address equals address_write while RegWrite=1 (address ≠ 0) returns data_write in the same cycle.
- Decode classes:
  - R-type (op 000000): reg_dst = rd, RegWrite = 1.
  - jr (func 001000): RegWrite = 0, target = rs.
  - jalr (func 001001): target = rs; links to rd.
  - lw (100011): MemRead, MemtoReg, ALUSrc, RegWrite; dest = rt.
  - sw (101011): MemWrite, ALUSrc.
  - beq (000100): Branch. bne (000101): BranchNot.
  - addi..lui (001xxx): ALUSrc, RegWrite; dest = rt.
  - j (000010): target = {pc_incrementado[31:28], instr[25:0], 2'b00}.
  - jal (000011): same target; links to 31.
  - Any other opcode: all controls 0 (NOP).
- Link rule (jal/jalr): reg_data1 = pc_incrementado, reg_data2 = 4, RegWrite = 1, ALUOp = ADD (100000 func code).
- Jumps:
  - jump_taken = valid_in && is_jump && !stall_out && !flush.
  - pc_jump is valid whenever jump_taken = 1.
- Load-use hazard: stall_out = valid_out && m_MemRead_out && rt_ex ≠ 0 && (rt_ex == rs_id || (rt_ex == rt_id && op uses rt)).
  - "op uses rt" = R-type, sw, beq, bne.
  - rt_ex is the registered rt output.
- Posedge update priority:
  1. flush → ID/EX loads a bubble (all controls 0, valid_out = 0).
  2. stall_out → bubble inserted; the instruction stays in ID.
  3. Otherwise → ID/EX loads the decoded instruction; valid_out = valid_in.
- Bubble = valid_out 0 and all control outputs 0. Data outputs are don't-care and are held at their previous values.
- Latency: one cycle from ID input to ID/EX output.
- A stall lasts exactly one cycle; afterwards the bubble no longer matches.
- flush and stall asserted together: flush wins; stall_out still reflects the comparison.
- A reset asserted mid-stall clears everything immediately.

Test Plan:
- Reset → all outputs 0. Then write R5 = 0x1234 via WB; next cycle decode `add r3,r5,r0` → reg_data1 = 0x1234, rd = 3, wb_RegWrite_out = 1, ALUOp = 100000.
- Bypass: WB writes R7 = 0xAAAA in the same cycle as ID reads R7 → reg_data1 = 0xAAAA. Repeat with BYPASS_EN = 0 → old value. A write to R0 → reads stay 0.
- Load-use: `lw r2,0(r1)` then `add r4,r2,r3` → stall_out = 1 for exactly 1 cycle, one bubble (valid_out 0, controls 0), then add issues. `lw r2` followed by `addi r4,r3,1` → no stall.
- `jal 0x0000100` with pc_incrementado = 0x40000008:
  - jump_taken = 1, pc_jump = 0x40000400.
  - Next cycle: rd = 31, reg_data1 = 0x40000008, reg_data2 = 4.
- `jr r9` (R9 = 0x80) → pc_jump = 0x80, wb_RegWrite_out = 0. The same jr with flush = 1 → jump_taken = 0 and a bubble.
- Assert reset during a stall cycle → outputs 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/instruction_decode_pipe.sv
// Instruction decode stage: register file with WB write-through, MIPS-style
// control decode, load-use hazard detection, combinational jump redirect,
// and a registered ID/EX bundle toward the execute stage.
module instruction_decode_pipe #(
  parameter int B         = 32,  // data / instruction width (>= 32)
  parameter int W         = 5,   // register address bits
  parameter int BYPASS_EN = 1,   // forward same-cycle WB write to ID reads
  parameter int HAZARD_EN = 1    // enable load-use stall detection
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_in,
  input  logic [B-1:0] instruction,
  input  logic [B-1:0] pc_incrementado,
  input  logic         flush,
  input  logic         RegWrite,
  input  logic [W-1:0] address_write,
  input  logic [B-1:0] data_write,
  output logic         stall_out,
  output logic         jump_taken,
  output logic [B-1:0] pc_jump,
  output logic         valid_out,
  output logic [B-1:0] reg_data1,
  output logic [B-1:0] reg_data2,
  output logic [B-1:0] sgn_extend_data_imm,
  output logic [W-1:0] rt,
  output logic [W-1:0] rd,
  output logic         wb_RegWrite_out,
  output logic         wb_MemtoReg_out,
  output logic         m_MemRead_out,
  output logic         m_MemWrite_out,
  output logic         m_Branch_out,
  output logic         m_BranchNot_out,
  output logic         ex_ALUSrc_out,
  output logic [5:0]   ex_ALUOp_out
);

  localparam int DEPTH = 1 << W;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [5:0] FN_ADD   = 6'b100000;

  localparam logic [W-1:0] LINK_REG = W'(31);

  // Control bundle bit positions inside ctrl vectors
  localparam int C_REGWRITE  = 6;
  localparam int C_MEMTOREG  = 5;
  localparam int C_MEMREAD   = 4;
  localparam int C_MEMWRITE  = 3;
  localparam int C_BRANCH    = 2;
  localparam int C_BRANCHNOT = 1;
  localparam int C_ALUSRC    = 0;

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [5:0]   op;
  logic [5:0]   func;
  logic [W-1:0] rs_addr;
  logic [W-1:0] rt_addr;
  logic [W-1:0] rd_addr;
  logic [B-1:0] imm_ext;

  assign op      = instruction[31:26];
  assign func    = instruction[5:0];
  assign rs_addr = W'(instruction[25:21]);
  assign rt_addr = W'(instruction[20:16]);
  assign rd_addr = W'(instruction[15:11]);
  assign imm_ext = {{(B-16){instruction[15]}}, instruction[15:0]};

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [B-1:0] rf_reg [DEPTH];

  // WB write port; register 0 is never written so it stays at its reset value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf_reg[i] <= '0;
      end
    end else if (RegWrite && (address_write != '0)) begin
      rf_reg[address_write] <= data_write;
    end
  end

  // Two asynchronous read ports: index 0 = rs, index 1 = rt
  logic [1:0][W-1:0] port_addr;
  logic [1:0][B-1:0] port_data;

  assign port_addr = {rt_addr, rs_addr};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
      logic bypass_hit;
      assign bypass_hit = (BYPASS_EN != 0) && RegWrite &&
                          (address_write == port_addr[gi]);
      assign port_data[gi] = (port_addr[gi] == '0) ? '0 :
                             bypass_hit            ? data_write :
                                                     rf_reg[port_addr[gi]];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic [6:0]   dec_ctrl;
  logic [5:0]   dec_aluop;
  logic [W-1:0] dec_dest;
  logic         is_jump;
  logic         jump_from_reg;
  logic         is_link;
  logic         uses_rt;

  // Classify the opcode and produce the control word for the ID/EX bundle
  always_comb begin
    dec_ctrl      = '0;
    dec_aluop     = op;
    dec_dest      = rt_addr;
    is_jump       = 1'b0;
    jump_from_reg = 1'b0;
    is_link       = 1'b0;
    uses_rt       = 1'b0;
    case (op)
      OP_RTYPE: begin
        uses_rt   = 1'b1;
        dec_aluop = func;
        dec_dest  = rd_addr;
        if (func == FN_JR) begin
          is_jump       = 1'b1;
          jump_from_reg = 1'b1;
        end else if (func == FN_JALR) begin
          is_jump                = 1'b1;
          jump_from_reg          = 1'b1;
          is_link                = 1'b1;
          dec_ctrl[C_REGWRITE]   = 1'b1;
        end else begin
          dec_ctrl[C_REGWRITE]   = 1'b1;
        end
      end
      OP_J: begin
        is_jump = 1'b1;
      end
      OP_JAL: begin
        is_jump              = 1'b1;
        is_link              = 1'b1;
        dec_ctrl[C_REGWRITE] = 1'b1;
        dec_dest             = LINK_REG;
      end
      OP_LW: begin
        dec_ctrl[C_MEMREAD]  = 1'b1;
        dec_ctrl[C_MEMTOREG] = 1'b1;
        dec_ctrl[C_ALUSRC]   = 1'b1;
        dec_ctrl[C_REGWRITE] = 1'b1;
      end
      OP_SW: begin
        uses_rt              = 1'b1;
        dec_ctrl[C_MEMWRITE] = 1'b1;
        dec_ctrl[C_ALUSRC]   = 1'b1;
      end
      OP_BEQ: begin
        uses_rt            = 1'b1;
        dec_ctrl[C_BRANCH] = 1'b1;
      end
      OP_BNE: begin
        uses_rt               = 1'b1;
        dec_ctrl[C_BRANCHNOT] = 1'b1;
      end
      default: begin
        if (op[5:3] == 3'b001) begin
          // addi .. lui: immediate ALU ops writing rt
          dec_ctrl[C_ALUSRC]   = 1'b1;
          dec_ctrl[C_REGWRITE] = 1'b1;
        end else begin
          // Unknown opcode behaves as a NOP
          dec_aluop = '0;
        end
      end
    endcase
    // Link instructions compute pc_incrementado + 4 in EX
    if (is_link) begin
      dec_aluop = FN_ADD;
    end
  end

  // Operand selection: link instructions substitute the return-address inputs
  logic [B-1:0] operand1;
  logic [B-1:0] operand2;

  assign operand1 = is_link ? pc_incrementado : port_data[0];
  assign operand2 = is_link ? {{(B-3){1'b0}}, 3'd4} : port_data[1];

  // ---------------------------------------------------------------------------
  // Jump redirect (combinational toward IF)
  // ---------------------------------------------------------------------------
  assign pc_jump    = jump_from_reg ? port_data[0]
                                    : {pc_incrementado[B-1:28], instruction[25:0], 2'b00};
  assign jump_taken = valid_in && is_jump && !stall_out && !flush;

  // ---------------------------------------------------------------------------
  // Load-use hazard detection against the load sitting in ID/EX
  // ---------------------------------------------------------------------------
  logic         valid_reg;
  logic [6:0]   ctrl_reg;
  logic [5:0]   aluop_reg;
  logic [W-1:0] rt_reg;

  generate
    if (HAZARD_EN != 0) begin : g_hazard
      assign stall_out = valid_reg && ctrl_reg[C_MEMREAD] && (rt_reg != '0) &&
                         ((rt_reg == rs_addr) || ((rt_reg == rt_addr) && uses_rt));
    end else begin : g_no_hazard
      assign stall_out = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // ID/EX register
  // ---------------------------------------------------------------------------
  logic         valid_next;
  logic [6:0]   ctrl_next;
  logic [5:0]   aluop_next;
  logic         load_data;

  // Flush beats stall; either one turns this cycle's load into a bubble
  always_comb begin
    valid_next = valid_in;
    ctrl_next  = dec_ctrl;
    aluop_next = dec_aluop;
    load_data  = 1'b1;
    if (flush || stall_out) begin
      valid_next = 1'b0;
      ctrl_next  = '0;
      aluop_next = '0;
      load_data  = 1'b0;
    end
  end

  // Valid and control half of ID/EX; bubbles clear it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
      aluop_reg <= '0;
    end else begin
      valid_reg <= valid_next;
      ctrl_reg  <= ctrl_next;
      aluop_reg <= aluop_next;
    end
  end

  logic [B-1:0] data1_reg;
  logic [B-1:0] data2_reg;
  logic [B-1:0] imm_reg;
  logic [W-1:0] dest_reg;

  // Data half of ID/EX; held across bubbles since EX ignores it then
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data1_reg <= '0;
      data2_reg <= '0;
      imm_reg   <= '0;
      rt_reg    <= '0;
      dest_reg  <= '0;
    end else if (load_data) begin
      data1_reg <= operand1;
      data2_reg <= operand2;
      imm_reg   <= imm_ext;
      rt_reg    <= rt_addr;
      dest_reg  <= dec_dest;
    end
  end

  assign valid_out           = valid_reg;
  assign reg_data1           = data1_reg;
  assign reg_data2           = data2_reg;
  assign sgn_extend_data_imm = imm_reg;
  assign rt                  = rt_reg;
  assign rd                  = dest_reg;
  assign wb_RegWrite_out     = ctrl_reg[C_REGWRITE];
  assign wb_MemtoReg_out     = ctrl_reg[C_MEMTOREG];
  assign m_MemRead_out       = ctrl_reg[C_MEMREAD];
  assign m_MemWrite_out      = ctrl_reg[C_MEMWRITE];
  assign m_Branch_out        = ctrl_reg[C_BRANCH];
  assign m_BranchNot_out     = ctrl_reg[C_BRANCHNOT];
  assign ex_ALUSrc_out       = ctrl_reg[C_ALUSRC];
  assign ex_ALUOp_out        = aluop_reg;

endmodule
